// File: rtl/id_v2_pkg.sv
// Shared decode constants, control struct and the instruction decoder for id_stage_v2.
package id_v2_pkg;

  typedef enum logic {ST_RUN, ST_HOLD} state_t;

  // ALU codes; branch codes are contiguous so EX can recognise them as a group
  localparam logic [4:0] alu_add  = 5'b00000;
  localparam logic [4:0] alu_addu = 5'b00001;
  localparam logic [4:0] alu_sub  = 5'b00010;
  localparam logic [4:0] alu_subu = 5'b00011;
  localparam logic [4:0] alu_and  = 5'b00100;
  localparam logic [4:0] alu_or   = 5'b00101;
  localparam logic [4:0] alu_xor  = 5'b00110;
  localparam logic [4:0] alu_nor  = 5'b00111;
  localparam logic [4:0] alu_slt  = 5'b01000;
  localparam logic [4:0] alu_sltu = 5'b01001;
  localparam logic [4:0] alu_beq  = 5'b01010;
  localparam logic [4:0] alu_bne  = 5'b01011;
  localparam logic [4:0] alu_bgez = 5'b01100;
  localparam logic [4:0] alu_bgtz = 5'b01101;
  localparam logic [4:0] alu_blez = 5'b01110;
  localparam logic [4:0] alu_bltz = 5'b01111;
  localparam logic [4:0] alu_sll  = 5'b10000;
  localparam logic [4:0] alu_srl  = 5'b10001;
  localparam logic [4:0] alu_sra  = 5'b10010;
  localparam logic [4:0] alu_lui  = 5'b10011;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE    = 6'h05, OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07, OP_ADDI   = 6'h08, OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a, OP_SLTIU  = 6'h0b, OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d, OP_XORI   = 6'h0e, OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23, OP_SW     = 6'h2b;

  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL  = 6'h02, FN_SRA = 6'h03, FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND = 6'h24, FN_OR   = 6'h25, FN_XOR = 6'h26, FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2a, FN_SLTU = 6'h2b;

  typedef struct packed {
    logic       valid;
    logic       memtoreg;
    logic       regwrite;
    logic       memwrite;
    logic       memread;
    logic       alusrca;
    logic       alusrcb;
    logic       regdst;
    logic [4:0] alucode;
  } ctrl_t;

  function automatic ctrl_t imm_ctrl(input logic [4:0] code);
    ctrl_t c;
    c = '0;
    c.regwrite = 1'b1;
    c.alusrcb  = 1'b1;
    c.alucode  = code;
    return c;
  endfunction

  // valid is left 0 here; the stage owns it. Unknown encodings give all-zero control.
  function automatic ctrl_t decode(input logic [31:0] ins);
    ctrl_t c;
    c = '0;
    case (ins[31:26])
      OP_RTYPE: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
        case (ins[5:0])
          FN_ADD:  c.alucode = alu_add;
          FN_ADDU: c.alucode = alu_addu;
          FN_SUB:  c.alucode = alu_sub;
          FN_SUBU: c.alucode = alu_subu;
          FN_AND:  c.alucode = alu_and;
          FN_OR:   c.alucode = alu_or;
          FN_XOR:  c.alucode = alu_xor;
          FN_NOR:  c.alucode = alu_nor;
          FN_SLT:  c.alucode = alu_slt;
          FN_SLTU: c.alucode = alu_sltu;
          FN_SLL:  begin c.alucode = alu_sll; c.alusrca = 1'b1; end
          FN_SRL:  begin c.alucode = alu_srl; c.alusrca = 1'b1; end
          FN_SRA:  begin c.alucode = alu_sra; c.alusrca = 1'b1; end
          default: c = '0;  // jr and unknown functs write nothing
        endcase
      end
      OP_ADDI:  c = imm_ctrl(alu_add);
      OP_ADDIU: c = imm_ctrl(alu_addu);
      OP_SLTI:  c = imm_ctrl(alu_slt);
      OP_SLTIU: c = imm_ctrl(alu_sltu);
      OP_ANDI:  c = imm_ctrl(alu_and);
      OP_ORI:   c = imm_ctrl(alu_or);
      OP_XORI:  c = imm_ctrl(alu_xor);
      OP_LUI:   c = imm_ctrl(alu_lui);
      OP_LW: begin
        c = imm_ctrl(alu_add);
        c.memread  = 1'b1;
        c.memtoreg = 1'b1;
      end
      OP_SW: begin
        c.memwrite = 1'b1;
        c.alusrcb  = 1'b1;
        c.alucode  = alu_add;
      end
      OP_BEQ:  c.alucode = alu_beq;
      OP_BNE:  c.alucode = alu_bne;
      OP_BLEZ: c.alucode = alu_blez;
      OP_BGTZ: c.alucode = alu_bgtz;
      OP_REGIMM: begin
        case (ins[20:16])
          5'd0:    c.alucode = alu_bltz;
          5'd1:    c.alucode = alu_bgez;
          default: c = '0;
        endcase
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_v2_regfile.sv
// NREG x XLEN register file, two combinational read ports, $0 hard-wired to zero.
// Build option ID_BYPASS_EN: a same-cycle WB write is forwarded to matching reads.
module id_v2_regfile #(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [AW-1:0]   i_raddr_a,
  input  logic [AW-1:0]   i_raddr_b,
  output logic [XLEN-1:0] o_rdata_a,
  output logic [XLEN-1:0] o_rdata_b
);

  logic [XLEN-1:0] r_mem [NREG];
  logic            w_byp_a, w_byp_b;

  // Storage is deliberately not reset; $0 is never written
  always_ff @(posedge clk) begin
    if (i_we && (i_waddr != '0)) r_mem[i_waddr] <= i_wdata;
  end

`ifdef ID_BYPASS_EN
  assign w_byp_a = i_we && (i_waddr != '0) && (i_waddr == i_raddr_a);
  assign w_byp_b = i_we && (i_waddr != '0) && (i_waddr == i_raddr_b);
`else
  assign w_byp_a = 1'b0;
  assign w_byp_b = 1'b0;
`endif

  assign o_rdata_a = (i_raddr_a == '0) ? '0 : w_byp_a ? i_wdata : r_mem[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == '0) ? '0 : w_byp_b ? i_wdata : r_mem[i_raddr_b];

endmodule

// File: rtl/id_stage_v2.sv
// MIPS decode stage: decode, register file, load-use stall FSM, branch/J/JR
// resolution and a registered ID/EX boundary.
// Build option ID_BYPASS_EN: WB-to-ID forwarding; without it a WB match stalls one cycle.
module id_stage_v2
  import id_v2_pkg::*;
#(
  parameter  int XLEN     = 32,
  parameter  int NREG     = 32,
  parameter  int LOAD_LAT = 1,
  localparam int AW       = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     instr_id,
  input  logic [XLEN-1:0] next_pc_id,
  input  logic            valid_id,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_memread,
  input  logic [AW-1:0]   ex_waddr,
  output logic            pc_if_write,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_addr,
  output logic            flush_if,
  output logic            valid_ex,
  output logic            memtoreg_ex,
  output logic            regwrite_ex,
  output logic            memwrite_ex,
  output logic            memread_ex,
  output logic            alusrca_ex,
  output logic            alusrcb_ex,
  output logic            regdst_ex,
  output logic [4:0]      alucode_ex,
  output logic [XLEN-1:0] rs_data_ex,
  output logic [XLEN-1:0] rt_data_ex,
  output logic [XLEN-1:0] imm_ex,
  output logic [XLEN-1:0] sa_ex,
  output logic [AW-1:0]   rs_addr_ex,
  output logic [AW-1:0]   rt_addr_ex,
  output logic [AW-1:0]   rd_addr_ex
);

  logic [AW-1:0]   w_rs, w_rt, w_rd;
  logic [XLEN-1:0] w_rs_val, w_rt_val, w_imm, w_sa, w_br_tgt, w_j_tgt;
  logic            w_ld_haz, w_wb_haz, w_stall, w_taken, w_is_j, w_is_jr, w_rs_neg, w_rs_zero;
  ctrl_t           w_dec, r_ctrl;
  state_t          r_state, w_nstate;
  logic [2:0]      r_stall_cnt, w_ncnt;
  logic [XLEN-1:0] r_rs_data, r_rt_data, r_imm, r_sa;
  logic [AW-1:0]   r_rs_addr, r_rt_addr, r_rd_addr;

  assign w_rs    = AW'(instr_id[25:21]);
  assign w_rt    = AW'(instr_id[20:16]);
  assign w_rd    = AW'(instr_id[15:11]);
  assign w_imm   = {{(XLEN-16){instr_id[15]}}, instr_id[15:0]};
  assign w_sa    = {{(XLEN-5){1'b0}}, instr_id[10:6]};
  assign w_is_j  = (instr_id[31:26] == OP_J);
  assign w_is_jr = (instr_id[31:26] == OP_RTYPE) && (instr_id[5:0] == FN_JR);

  id_v2_regfile #(.XLEN(XLEN), .NREG(NREG)) u_rf (
    .clk       (clk),
    .i_we      (wb_we),
    .i_waddr   (wb_addr),
    .i_wdata   (wb_data),
    .i_raddr_a (w_rs),
    .i_raddr_b (w_rt),
    .o_rdata_a (w_rs_val),
    .o_rdata_b (w_rt_val)
  );

  assign w_ld_haz = valid_id && ex_memread && (ex_waddr != '0) &&
                    ((ex_waddr == w_rs) || (ex_waddr == w_rt));
`ifdef ID_BYPASS_EN
  assign w_wb_haz = 1'b0;
`else
  // No forwarding: wait one cycle for the write to land in the array
  assign w_wb_haz = valid_id && wb_we && (wb_addr != '0) &&
                    ((wb_addr == w_rs) || (wb_addr == w_rt));
`endif

  // Bubbles carry no control so nothing downstream can act on them
  always_comb begin
    w_dec       = decode(instr_id);
    w_dec.valid = 1'b1;
    if (!valid_id) w_dec = '0;
  end

  // Stall FSM next state: only a load hazard holds beyond the first cycle
  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_stall_cnt;
    w_stall  = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_ld_haz || w_wb_haz) begin
          w_stall = 1'b1;
          if (w_ld_haz && (LOAD_LAT > 1)) begin
            w_nstate = ST_HOLD;
            w_ncnt   = 3'(LOAD_LAT - 1);
          end
        end
      end
      ST_HOLD: begin
        w_stall = 1'b1;
        w_ncnt  = r_stall_cnt - 3'd1;
        if (r_stall_cnt <= 3'd1) w_nstate = ST_RUN;
      end
      default: w_nstate = ST_RUN;
    endcase
  end

  // Stall FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_stall_cnt <= 3'd0;
    end else begin
      r_state     <= w_nstate;
      r_stall_cnt <= w_ncnt;
    end
  end

  assign w_rs_neg  = w_rs_val[XLEN-1];
  assign w_rs_zero = (w_rs_val == '0);

  // Branch condition on post-bypass operands; J/JR are unconditional
  always_comb begin
    case (w_dec.alucode)
      alu_beq:  w_taken = (w_rs_val == w_rt_val);
      alu_bne:  w_taken = (w_rs_val != w_rt_val);
      alu_bgez: w_taken = !w_rs_neg;
      alu_bgtz: w_taken = !w_rs_neg && !w_rs_zero;
      alu_blez: w_taken = w_rs_neg || w_rs_zero;
      alu_bltz: w_taken = w_rs_neg;
      default:  w_taken = 1'b0;
    endcase
    if (w_is_j || w_is_jr) w_taken = 1'b1;
  end

  assign w_br_tgt      = next_pc_id + (w_imm << 2);
  assign w_j_tgt       = {next_pc_id[XLEN-1:28], instr_id[25:0], 2'b00};
  assign redirect      = valid_id && w_taken && !w_stall;
  assign redirect_addr = w_is_jr ? w_rs_val : (w_is_j ? w_j_tgt : w_br_tgt);
  assign flush_if      = redirect;
  assign pc_if_write   = !w_stall;

  // ID/EX register: a stall injects a bubble in place of the held instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl    <= '0;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm     <= '0;
      r_sa      <= '0;
      r_rs_addr <= '0;
      r_rt_addr <= '0;
      r_rd_addr <= '0;
    end else begin
      r_ctrl    <= w_stall ? '0 : w_dec;
      r_rs_data <= w_rs_val;
      r_rt_data <= w_rt_val;
      r_imm     <= w_imm;
      r_sa      <= w_sa;
      r_rs_addr <= w_rs;
      r_rt_addr <= w_rt;
      r_rd_addr <= w_rd;
    end
  end

  assign valid_ex    = r_ctrl.valid;
  assign memtoreg_ex = r_ctrl.memtoreg;
  assign regwrite_ex = r_ctrl.regwrite;
  assign memwrite_ex = r_ctrl.memwrite;
  assign memread_ex  = r_ctrl.memread;
  assign alusrca_ex  = r_ctrl.alusrca;
  assign alusrcb_ex  = r_ctrl.alusrcb;
  assign regdst_ex   = r_ctrl.regdst;
  assign alucode_ex  = r_ctrl.alucode;
  assign rs_data_ex  = r_rs_data;
  assign rt_data_ex  = r_rt_data;
  assign imm_ex      = r_imm;
  assign sa_ex       = r_sa;
  assign rs_addr_ex  = r_rs_addr;
  assign rt_addr_ex  = r_rt_addr;
  assign rd_addr_ex  = r_rd_addr;

endmodule

// File: tb/tb_id_stage_v2.sv
// Directed bench for id_stage_v2 (LOAD_LAT=2); expectations follow ID_BYPASS_EN.
module tb_id_stage_v2;
  import id_v2_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr_id, next_pc_id, wb_data, redirect_addr;
  logic        valid_id, wb_we, ex_memread;
  logic [4:0]  wb_addr, ex_waddr;
  logic        pc_if_write, redirect, flush_if;
  logic        valid_ex, memtoreg_ex, regwrite_ex, memwrite_ex, memread_ex;
  logic        alusrca_ex, alusrcb_ex, regdst_ex;
  logic [4:0]  alucode_ex, rs_addr_ex, rt_addr_ex, rd_addr_ex;
  logic [31:0] rs_data_ex, rt_data_ex, imm_ex, sa_ex;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  id_stage_v2 #(.XLEN(32), .NREG(32), .LOAD_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .instr_id(instr_id), .next_pc_id(next_pc_id),
    .valid_id(valid_id), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_memread(ex_memread), .ex_waddr(ex_waddr), .pc_if_write(pc_if_write),
    .redirect(redirect), .redirect_addr(redirect_addr), .flush_if(flush_if),
    .valid_ex(valid_ex), .memtoreg_ex(memtoreg_ex), .regwrite_ex(regwrite_ex),
    .memwrite_ex(memwrite_ex), .memread_ex(memread_ex), .alusrca_ex(alusrca_ex),
    .alusrcb_ex(alusrcb_ex), .regdst_ex(regdst_ex), .alucode_ex(alucode_ex),
    .rs_data_ex(rs_data_ex), .rt_data_ex(rt_data_ex), .imm_ex(imm_ex), .sa_ex(sa_ex),
    .rs_addr_ex(rs_addr_ex), .rt_addr_ex(rt_addr_ex), .rd_addr_ex(rd_addr_ex)
  );

  function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, sa, input logic [5:0] fn);
    return {OP_RTYPE, rs, rt, rd, sa, fn};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_id = 1'b0; instr_id = '0; next_pc_id = '0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    ex_memread = 1'b0; ex_waddr = '0;
  endtask

  task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
    valid_id = 1'b0; wb_we = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_we = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    #3 rst_n = 1'b1;
    tick();
    instr_id = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd5); valid_id = 1'b1;
    tick();
    #2 rst_n = 1'b0;
    #1;
    total++; if (valid_ex !== 1'b0) begin bad++; $display("FAIL rst_valid_ex got=%0b exp=0", valid_ex); end
    total++; if (regwrite_ex !== 1'b0) begin bad++; $display("FAIL rst_regwrite_ex got=%0b exp=0", regwrite_ex); end
    total++; if ({imm_ex, rt_addr_ex, alusrcb_ex} !== '0) begin bad++; $display("FAIL rst_ex_fields got=%h exp=0", {imm_ex, rt_addr_ex, alusrcb_ex}); end
    total++; if (pc_if_write !== 1'b1) begin bad++; $display("FAIL rst_pcw got=%0b exp=1", pc_if_write); end
    total++; if (redirect !== 1'b0) begin bad++; $display("FAIL rst_redirect got=%0b exp=0", redirect); end
    #1 rst_n = 1'b1;
    tick();
    total++; if (imm_ex !== 32'd5) begin bad++; $display("FAIL addi_imm got=%h exp=5", imm_ex); end
    total++; if (regwrite_ex !== 1'b1) begin bad++; $display("FAIL addi_regwrite got=%0b exp=1", regwrite_ex); end
    total++; if (rt_addr_ex !== 5'd1) begin bad++; $display("FAIL addi_rt_addr got=%0d exp=1", rt_addr_ex); end
    total++; if ({valid_ex, alusrcb_ex, regdst_ex} !== 3'b110) begin bad++; $display("FAIL addi_ctrl got=%b exp=110", {valid_ex, alusrcb_ex, regdst_ex}); end
  endtask

  task automatic test_reset_hold();
    idle();
    instr_id = enc_r(5'd3, 5'd2, 5'd4, 5'd0, FN_ADD); valid_id = 1'b1;
    ex_memread = 1'b1; ex_waddr = 5'd3;
    #1;
    total++; if (pc_if_write !== 1'b0) begin bad++; $display("FAIL hold_pre_stall got=%0b exp=0", pc_if_write); end
    tick();
    ex_memread = 1'b0; ex_waddr = '0;
    #1;
    total++; if (pc_if_write !== 1'b0) begin bad++; $display("FAIL hold_in_hold got=%0b exp=0", pc_if_write); end
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    #1;
    total++; if (pc_if_write !== 1'b1) begin bad++; $display("FAIL hold_abandoned got=%0b exp=1", pc_if_write); end
    tick();
    idle();
  endtask

  task automatic test_load_use();
    idle();
    instr_id = enc_r(5'd3, 5'd2, 5'd4, 5'd0, FN_ADD); valid_id = 1'b1;
    ex_memread = 1'b1; ex_waddr = 5'd3;
    #1;
    total++; if (pc_if_write !== 1'b0) begin bad++; $display("FAIL lu_c0_pcw got=%0b exp=0", pc_if_write); end
    tick();
    ex_memread = 1'b0; ex_waddr = '0;   // bubble now sits in EX
    #1;
    total++; if (pc_if_write !== 1'b0) begin bad++; $display("FAIL lu_c1_pcw got=%0b exp=0", pc_if_write); end
    total++; if (valid_ex !== 1'b0) begin bad++; $display("FAIL lu_c1_valid_ex got=%0b exp=0", valid_ex); end
    tick();
    total++; if (pc_if_write !== 1'b1) begin bad++; $display("FAIL lu_c2_pcw got=%0b exp=1", pc_if_write); end
    total++; if (valid_ex !== 1'b0) begin bad++; $display("FAIL lu_c2_valid_ex got=%0b exp=0", valid_ex); end
    tick();
    total++; if ({valid_ex, regwrite_ex, regdst_ex} !== 3'b111) begin bad++; $display("FAIL lu_add_ctrl got=%b exp=111", {valid_ex, regwrite_ex, regdst_ex}); end
    total++; if (rd_addr_ex !== 5'd4) begin bad++; $display("FAIL lu_add_rd got=%0d exp=4", rd_addr_ex); end
    total++; if (rt_data_ex !== 32'd7) begin bad++; $display("FAIL lu_add_rt_data got=%h exp=7", rt_data_ex); end
    total++; if (alucode_ex !== alu_add) begin bad++; $display("FAIL lu_add_alucode got=%b exp=%b", alucode_ex, alu_add); end
    idle();
  endtask

  task automatic test_ex_r0();
    idle();
    instr_id = enc_r(5'd0, 5'd0, 5'd4, 5'd0, FN_ADD); valid_id = 1'b1;
    ex_memread = 1'b1; ex_waddr = 5'd0;
    #1;
    total++; if (pc_if_write !== 1'b1) begin bad++; $display("FAIL exr0_no_stall got=%0b exp=1", pc_if_write); end
    instr_id = enc_r(5'd3, 5'd0, 5'd4, 5'd0, FN_ADD); valid_id = 1'b0; ex_waddr = 5'd3;
    #1;
    total++; if (pc_if_write !== 1'b1) begin bad++; $display("FAIL bubble_no_stall got=%0b exp=1", pc_if_write); end
    tick();
    idle();
  endtask

  task automatic test_branch();
    idle();
    next_pc_id = 32'h100; valid_id = 1'b1;
    instr_id = enc_i(OP_BEQ, 5'd1, 5'd2, 16'd4);
    #1;
    total++; if ({redirect, flush_if} !== 2'b11) begin bad++; $display("FAIL beq_taken got=%b exp=11", {redirect, flush_if}); end
    total++; if (redirect_addr !== 32'h110) begin bad++; $display("FAIL beq_target got=%h exp=110", redirect_addr); end
    tick();
    total++; if ({valid_ex, regwrite_ex} !== 2'b10) begin bad++; $display("FAIL beq_ex_ctrl got=%b exp=10", {valid_ex, regwrite_ex}); end
    total++; if (alucode_ex !== alu_beq) begin bad++; $display("FAIL beq_alucode got=%b exp=%b", alucode_ex, alu_beq); end
    wr_reg(5'd2, 32'd8);
    valid_id = 1'b1;
    #1;
    total++; if ({redirect, flush_if} !== 2'b00) begin bad++; $display("FAIL beq_not_taken got=%b exp=00", {redirect, flush_if}); end
    tick();
    instr_id = enc_i(OP_BNE, 5'd1, 5'd2, 16'hFFFF);
    #1;
    total++; if ({redirect, redirect_addr} !== {1'b1, 32'hFC}) begin bad++; $display("FAIL bne_back got=%b/%h exp=1/fc", redirect, redirect_addr); end
    tick();
    instr_id = enc_i(OP_BGTZ, 5'd1, 5'd0, 16'd2);
    #1;
    total++; if ({redirect, redirect_addr} !== {1'b1, 32'h108}) begin bad++; $display("FAIL bgtz got=%b/%h exp=1/108", redirect, redirect_addr); end
    instr_id = enc_i(OP_BLEZ, 5'd1, 5'd0, 16'd2);
    #1;
    total++; if (redirect !== 1'b0) begin bad++; $display("FAIL blez got=%0b exp=0", redirect); end
    tick();
    wr_reg(5'd6, 32'h8000_0000);
    valid_id = 1'b1;
    instr_id = enc_i(OP_REGIMM, 5'd6, 5'd0, 16'd1);
    #1;
    total++; if ({redirect, redirect_addr} !== {1'b1, 32'h104}) begin bad++; $display("FAIL bltz got=%b/%h exp=1/104", redirect, redirect_addr); end
    instr_id = enc_i(OP_REGIMM, 5'd6, 5'd1, 16'd1);
    #1;
    total++; if (redirect !== 1'b0) begin bad++; $display("FAIL bgez_neg got=%0b exp=0", redirect); end
    tick();
    next_pc_id = 32'h1000_0004;
    instr_id = {OP_J, 26'h40};
    #1;
    total++; if ({redirect, redirect_addr} !== {1'b1, 32'h1000_0100}) begin bad++; $display("FAIL j_target got=%b/%h exp=1/10000100", redirect, redirect_addr); end
    tick();
    instr_id = enc_i(OP_BEQ, 5'd1, 5'd1, 16'd4);
    ex_memread = 1'b1; ex_waddr = 5'd1;
    #1;
    total++; if ({redirect, flush_if, pc_if_write} !== 3'b000) begin bad++; $display("FAIL beq_stalled got=%b exp=000", {redirect, flush_if, pc_if_write}); end
    tick();
    idle();
    tick();
    tick();
  endtask

  task automatic test_bypass_jr();
    wr_reg(5'd5, 32'h1234);
    instr_id = enc_r(5'd5, 5'd0, 5'd0, 5'd0, FN_JR); valid_id = 1'b1;
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD;
    #1;
`ifdef ID_BYPASS_EN
    total++; if ({redirect, pc_if_write, redirect_addr} !== {2'b11, 32'hDEAD}) begin bad++; $display("FAIL jr_bypass got=%b%b/%h exp=11/dead", redirect, pc_if_write, redirect_addr); end
    tick();
`else
    total++; if ({redirect, pc_if_write} !== 2'b00) begin bad++; $display("FAIL jr_wb_stall got=%b exp=00", {redirect, pc_if_write}); end
    tick();
    wb_we = 1'b0;
    #1;
    total++; if ({redirect, redirect_addr} !== {1'b1, 32'hDEAD}) begin bad++; $display("FAIL jr_after_stall got=%b/%h exp=1/dead", redirect, redirect_addr); end
    tick();
`endif
    wb_we = 1'b0;
    total++; if ({valid_ex, regwrite_ex, rs_data_ex} !== {2'b10, 32'hDEAD}) begin bad++; $display("FAIL jr_ex got=%b%b/%h exp=10/dead", valid_ex, regwrite_ex, rs_data_ex); end
    idle();
  endtask

  task automatic test_r0();
    idle();
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF;
    tick();
    instr_id = enc_r(5'd0, 5'd0, 5'd7, 5'd0, FN_ADD); valid_id = 1'b1;
    #1;
    total++; if (pc_if_write !== 1'b1) begin bad++; $display("FAIL r0_no_stall got=%0b exp=1", pc_if_write); end
    tick();
    total++; if ({rs_data_ex, rt_data_ex} !== 64'd0) begin bad++; $display("FAIL r0_reads got=%h/%h exp=0/0", rs_data_ex, rt_data_ex); end
    idle();
  endtask

  task automatic test_decode();
    idle();
    valid_id = 1'b1;
    instr_id = enc_i(OP_LW, 5'd1, 5'd9, 16'hFFF8);
    tick();
    total++; if ({memread_ex, memtoreg_ex, regwrite_ex, alusrcb_ex, memwrite_ex} !== 5'b11110) begin bad++; $display("FAIL lw_ctrl got=%b exp=11110", {memread_ex, memtoreg_ex, regwrite_ex, alusrcb_ex, memwrite_ex}); end
    total++; if ({imm_ex, rs_data_ex} !== {32'hFFFF_FFF8, 32'd7}) begin bad++; $display("FAIL lw_data got=%h/%h exp=fffffff8/7", imm_ex, rs_data_ex); end
    instr_id = enc_i(OP_SW, 5'd1, 5'd2, 16'd4);
    tick();
    total++; if ({memwrite_ex, regwrite_ex, memread_ex, alusrcb_ex} !== 4'b1001) begin bad++; $display("FAIL sw_ctrl got=%b exp=1001", {memwrite_ex, regwrite_ex, memread_ex, alusrcb_ex}); end
    instr_id = enc_r(5'd0, 5'd2, 5'd8, 5'd3, FN_SLL);
    tick();
    total++; if ({sa_ex, alusrca_ex, alucode_ex} !== {32'd3, 1'b1, alu_sll}) begin bad++; $display("FAIL sll got=%h/%b/%b exp=3/1/%b", sa_ex, alusrca_ex, alucode_ex, alu_sll); end
    instr_id = 32'hFC00_0000;
    tick();
    total++; if ({valid_ex, memtoreg_ex, regwrite_ex, memwrite_ex, memread_ex, alusrca_ex, alusrcb_ex, regdst_ex, alucode_ex} !== 13'b1_0000000_00000) begin bad++; $display("FAIL illegal_ctrl got=%b exp=1000000000000", {valid_ex, memtoreg_ex, regwrite_ex, memwrite_ex, memread_ex, alusrca_ex, alusrcb_ex, regdst_ex, alucode_ex}); end
    valid_id = 1'b0;
    instr_id = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd5);
    tick();
    total++; if ({valid_ex, regwrite_ex} !== 2'b00) begin bad++; $display("FAIL bubble_ctrl got=%b exp=00", {valid_ex, regwrite_ex}); end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_reset_hold();
    wr_reg(5'd1, 32'd7);
    wr_reg(5'd2, 32'd7);
    test_load_use();
    test_ex_r0();
    test_branch();
    test_bypass_jr();
    test_r0();
    test_decode();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
